// File: rtl/phys_reg_file.sv
// Physical register file: async read ports with write bypass, sync write-back
// ports, per-register ready bit driven by rename alloc / write-back / flush.

module prf_entry #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WR     = 2,
  parameter int AW         = 6,
  parameter int ADDR       = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_WR-1:0]                wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]        wr_addr,
  input  logic [NUM_WR-1:0][DATA_WIDTH-1:0] wr_data,
  input  logic                             alloc_en,
  input  logic [AW-1:0]                    alloc_addr,
  input  logic                             flush,
  output logic [DATA_WIDTH-1:0]            data,
  output logic                             ready
);
  logic                  hit;
  logic [DATA_WIDTH-1:0] nxt;

  // Ascending scan so the highest-numbered matching port wins.
  always_comb begin
    hit = 1'b0;
    nxt = data;
    for (int j = 0; j < NUM_WR; j++)
      if (wr_en[j] && wr_addr[j] == AW'(ADDR)) begin
        hit = 1'b1;
        nxt = wr_data[j];
      end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data  <= '0;
      ready <= 1'b1;
    end else begin
      if (hit) data <= nxt;
      // Flush beats alloc beats write-back on the ready bit.
      if (flush)                                       ready <= 1'b1;
      else if (alloc_en && alloc_addr == AW'(ADDR))    ready <= 1'b0;
      else if (hit)                                    ready <= 1'b1;
    end
  end
endmodule

module prf_rd_port #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_PREGS  = 64,
  parameter int NUM_WR     = 2,
  parameter int AW         = 6
) (
  input  logic                                rst,
  input  logic [AW-1:0]                       addr,
  input  logic [NUM_PREGS-1:0][DATA_WIDTH-1:0] regs,
  input  logic [NUM_PREGS-1:0]                ready,
  input  logic [NUM_WR-1:0]                   wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]           wr_addr,
  input  logic [NUM_WR-1:0][DATA_WIDTH-1:0]   wr_data,
  output logic [DATA_WIDTH-1:0]               data,
  output logic                                rdy
);
  // While in reset the stored state is the answer; bypass is suppressed.
  always_comb begin
    data = regs[addr];
    rdy  = ready[addr];
    for (int j = 0; j < NUM_WR; j++)
      if (!rst && wr_en[j] && addr != '0 && wr_addr[j] == addr) begin
        data = wr_data[j];
        rdy  = 1'b1;
      end
  end
endmodule

module phys_reg_file #(
  parameter  int DATA_WIDTH = 32,
  parameter  int NUM_PREGS  = 64,
  parameter  int NUM_RD     = 4,
  parameter  int NUM_WR     = 2,
  localparam int AW         = $clog2(NUM_PREGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*AW-1:0]         rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_ready,
  input  logic                         alloc_en,
  input  logic [AW-1:0]                alloc_addr,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR*AW-1:0]         wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic                         flush,
  output logic [NUM_WR-1:0]            commit_valid,
  output logic                         wr_conflict
);
  logic [NUM_RD-1:0][AW-1:0]           ra;
  logic [NUM_RD-1:0][DATA_WIDTH-1:0]   rdd;
  logic [NUM_WR-1:0][AW-1:0]           wa;
  logic [NUM_WR-1:0][DATA_WIDTH-1:0]   wd;
  logic [NUM_WR-1:0]                   wr_nz;
  logic [NUM_PREGS-1:0][DATA_WIDTH-1:0] regs;
  logic [NUM_PREGS-1:0]                ready;
  logic                                conf;

  assign ra      = rd_addr;
  assign wa      = wr_addr;
  assign wd      = wr_data;
  assign rd_data = rdd;

  // Preg 0 has no storage: constant zero and always ready.
  assign regs[0]  = '0;
  assign ready[0] = 1'b1;

  genvar p, i, j;
  generate
    for (p = 1; p < NUM_PREGS; p++) begin : g_ent
      prf_entry #(.DATA_WIDTH(DATA_WIDTH), .NUM_WR(NUM_WR), .AW(AW), .ADDR(p)) u_ent (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wa),
        .wr_data   (wd),
        .alloc_en  (alloc_en),
        .alloc_addr(alloc_addr),
        .flush     (flush),
        .data      (regs[p]),
        .ready     (ready[p])
      );
    end

    for (i = 0; i < NUM_RD; i++) begin : g_rd
      prf_rd_port #(.DATA_WIDTH(DATA_WIDTH), .NUM_PREGS(NUM_PREGS), .NUM_WR(NUM_WR), .AW(AW)) u_rd (
        .rst    (rst),
        .addr   (ra[i]),
        .regs   (regs),
        .ready  (ready),
        .wr_en  (wr_en),
        .wr_addr(wa),
        .wr_data(wd),
        .data   (rdd[i]),
        .rdy    (rd_ready[i])
      );
    end

    for (j = 0; j < NUM_WR; j++) begin : g_nz
      assign wr_nz[j] = wr_en[j] && (wa[j] != '0);
    end
  endgenerate

  always_comb begin
    conf = 1'b0;
    for (int a = 0; a < NUM_WR; a++)
      for (int b = a + 1; b < NUM_WR; b++)
        if (wr_nz[a] && wr_nz[b] && wa[a] == wa[b]) conf = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      commit_valid <= '0;
      wr_conflict  <= 1'b0;
    end else begin
      commit_valid <= wr_nz;
      wr_conflict  <= wr_conflict | conf;
    end
  end
endmodule

// File: tb/tb_phys_reg_file.sv
// Bench for phys_reg_file: directed vector table, reset corner sequences and
// randomized traffic compared against an array-based reference model.

module tb_phys_reg_file;
  localparam int DW = 32;
  localparam int NP = 64;
  localparam int NR = 4;
  localparam int NW = 2;
  localparam int AW = 6;

  logic               clk = 1'b0;
  logic               rst;
  logic [NR*AW-1:0]   rd_addr;
  logic [NR*DW-1:0]   rd_data;
  logic [NR-1:0]      rd_ready;
  logic               alloc_en;
  logic [AW-1:0]      alloc_addr;
  logic [NW-1:0]      wr_en;
  logic [NW*AW-1:0]   wr_addr;
  logic [NW*DW-1:0]   wr_data;
  logic               flush;
  logic [NW-1:0]      commit_valid;
  logic               wr_conflict;

  phys_reg_file #(.DATA_WIDTH(DW), .NUM_PREGS(NP), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_ready(rd_ready),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .flush(flush), .commit_valid(commit_valid), .wr_conflict(wr_conflict)
  );

  always #5 clk = ~clk;

  // Reference model
  logic [DW-1:0] m_mem [NP];
  bit            m_rdy [NP];
  logic [NW-1:0] m_cv;
  bit            m_cf;

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    for (int a = 0; a < NP; a++) begin
      m_mem[a] = '0;
      m_rdy[a] = 1'b1;
    end
    m_cv = '0;
    m_cf = 1'b0;
  endtask

  task automatic model_update();
    int cnt [NP];
    logic [AW-1:0] a;
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < NP; k++) cnt[k] = 0;
    for (int j = 0; j < NW; j++) begin
      a = wr_addr[j*AW +: AW];
      m_cv[j] = wr_en[j] && a != 0;
      if (wr_en[j] && a != 0) begin
        m_mem[a] = wr_data[j*DW +: DW];
        m_rdy[a] = 1'b1;
        cnt[a]++;
      end
    end
    for (int k = 0; k < NP; k++) if (cnt[k] > 1) m_cf = 1'b1;
    if (alloc_en && alloc_addr != 0) m_rdy[alloc_addr] = 1'b0;
    if (flush) for (int k = 0; k < NP; k++) m_rdy[k] = 1'b1;
  endtask

  task automatic exp_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output bit r);
    d = m_mem[a];
    r = m_rdy[a];
    if (a == 0 || rst) begin
      d = (a == 0) ? '0 : m_mem[a];
      r = (a == 0) ? 1'b1 : m_rdy[a];
      return;
    end
    for (int j = 0; j < NW; j++)
      if (wr_en[j] && wr_addr[j*AW +: AW] == a) begin
        d = wr_data[j*DW +: DW];
        r = 1'b1;
      end
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] d;
    bit r;
    for (int i = 0; i < NR; i++) begin
      exp_read(rd_addr[i*AW +: AW], d, r);
      chk($sformatf("%s rd_data[%0d]", tag, i), rd_data[i*DW +: DW], d);
      chk($sformatf("%s rd_ready[%0d]", tag, i), {31'b0, rd_ready[i]}, {31'b0, r});
    end
    chk({tag, " commit_valid"}, {30'b0, commit_valid}, {30'b0, m_cv});
    chk({tag, " wr_conflict"}, {31'b0, wr_conflict}, {31'b0, m_cf});
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    alloc_en = 0; alloc_addr = '0; wr_en = '0; wr_addr = '0; wr_data = '0; flush = 0;
  endtask

  typedef struct {
    bit            ae;
    logic [AW-1:0] aa;
    logic [NW-1:0] we;
    logic [AW-1:0] wa0, wa1;
    logic [DW-1:0] wd0, wd1;
    bit            fl;
    logic [AW-1:0] ra;
    logic [DW-1:0] ed;
    bit            er;
    logic [NW-1:0] ecv;
    bit            ecf;
  } vec_t;

  function automatic vec_t mk(bit ae, int aa, logic [NW-1:0] we, int wa0, logic [DW-1:0] wd0,
                              int wa1, logic [DW-1:0] wd1, bit fl, int ra,
                              logic [DW-1:0] ed, bit er, logic [NW-1:0] ecv, bit ecf);
    vec_t v;
    v.ae = ae; v.aa = AW'(aa); v.we = we; v.wa0 = AW'(wa0); v.wd0 = wd0;
    v.wa1 = AW'(wa1); v.wd1 = wd1; v.fl = fl; v.ra = AW'(ra);
    v.ed = ed; v.er = er; v.ecv = ecv; v.ecf = ecf;
    return v;
  endfunction

  vec_t tbl [18];

  initial begin
    tbl[0]  = mk(1, 5, 2'b00, 0, 0, 0, 0, 0, 5, 32'h0, 1, 2'b00, 0);
    tbl[1]  = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 5, 32'h0, 0, 2'b00, 0);
    tbl[2]  = mk(0, 0, 2'b10, 0, 0, 5, 32'hDEADBEEF, 0, 5, 32'hDEADBEEF, 1, 2'b00, 0);
    tbl[3]  = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 1, 2'b10, 0);
    tbl[4]  = mk(0, 0, 2'b01, 0, 32'h1234, 0, 0, 0, 0, 32'h0, 1, 2'b00, 0);
    tbl[5]  = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 32'h0, 1, 2'b00, 0);
    tbl[6]  = mk(0, 0, 2'b11, 9, 32'h11, 9, 32'h22, 0, 9, 32'h22, 1, 2'b00, 0);
    tbl[7]  = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 9, 32'h22, 1, 2'b11, 1);
    tbl[8]  = mk(1, 7, 2'b00, 0, 0, 0, 0, 0, 7, 32'h0, 1, 2'b00, 1);
    tbl[9]  = mk(1, 8, 2'b00, 0, 0, 0, 0, 0, 7, 32'h0, 0, 2'b00, 1);
    tbl[10] = mk(1, 9, 2'b00, 0, 0, 0, 0, 0, 8, 32'h0, 0, 2'b00, 1);
    tbl[11] = mk(1, 10, 2'b00, 0, 0, 0, 0, 1, 9, 32'h22, 0, 2'b00, 1);
    tbl[12] = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 10, 32'h0, 1, 2'b00, 1);
    tbl[13] = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 7, 32'h0, 1, 2'b00, 1);
    tbl[14] = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 8, 32'h0, 1, 2'b00, 1);
    tbl[15] = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 9, 32'h22, 1, 2'b00, 1);
    tbl[16] = mk(1, 12, 2'b01, 12, 32'hAA, 0, 0, 0, 12, 32'hAA, 1, 2'b00, 1);
    tbl[17] = mk(0, 0, 2'b00, 0, 0, 0, 0, 0, 12, 32'hAA, 0, 2'b01, 1);

    // Reset state
    rst = 1'b1;
    idle();
    rd_addr = {6'd17, 6'd63, 6'd5, 6'd0};
    model_reset();
    @(negedge clk); @(negedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("reset rd_data[%0d]", i), rd_data[i*DW +: DW], 32'h0);
      chk($sformatf("reset rd_ready[%0d]", i), {31'b0, rd_ready[i]}, 32'h1);
    end
    chk("reset commit_valid", {30'b0, commit_valid}, 32'h0);
    chk("reset wr_conflict", {31'b0, wr_conflict}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table
    for (int n = 0; n < 18; n++) begin
      alloc_en = tbl[n].ae; alloc_addr = tbl[n].aa; wr_en = tbl[n].we;
      wr_addr = {tbl[n].wa1, tbl[n].wa0}; wr_data = {tbl[n].wd1, tbl[n].wd0}; flush = tbl[n].fl;
      rd_addr = {6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), tbl[n].ra};
      #1;
      chk($sformatf("vec%0d rd_data", n), rd_data[DW-1:0], tbl[n].ed);
      chk($sformatf("vec%0d rd_ready", n), {31'b0, rd_ready[0]}, {31'b0, tbl[n].er});
      chk($sformatf("vec%0d commit_valid", n), {30'b0, commit_valid}, {30'b0, tbl[n].ecv});
      chk($sformatf("vec%0d wr_conflict", n), {31'b0, wr_conflict}, {31'b0, tbl[n].ecf});
      check_all($sformatf("vec%0d", n));
      tick();
    end

    // Mid-stream reset with a pending write and alloc that must be discarded
    idle();
    wr_en = 2'b01; wr_addr = {6'd0, 6'd12}; wr_data = {32'h0, 32'h55};
    alloc_en = 1; alloc_addr = 6'd3;
    rd_addr = {6'd3, 6'd9, 6'd5, 6'd12};
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("midrst rd12 data", rd_data[DW-1:0], 32'h0);
    chk("midrst rd12 ready", {31'b0, rd_ready[0]}, 32'h1);
    chk("midrst rd5 data", rd_data[2*DW-1:DW], 32'h0);
    chk("midrst rd9 data", rd_data[3*DW-1:2*DW], 32'h0);
    chk("midrst wr_conflict", {31'b0, wr_conflict}, 32'h0);
    tick();
    rst = 1'b0;
    idle();
    #1;
    chk("postrst rd12 data", rd_data[DW-1:0], 32'h0);
    chk("postrst rd3 ready", {31'b0, rd_ready[3]}, 32'h1);
    chk("postrst commit_valid", {30'b0, commit_valid}, 32'h0);
    check_all("postrst");
    tick();

    // Randomized traffic against the model
    for (int c = 0; c < 500; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      if (rst) model_reset();
      alloc_en = $urandom_range(0, 1);
      alloc_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 15));
      wr_en = NW'($urandom_range(0, 3));
      for (int j = 0; j < NW; j++) begin
        wr_addr[j*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 15));
        wr_data[j*DW +: DW] = $urandom;
      end
      flush = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < NR; i++)
        rd_addr[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 63)) : AW'($urandom_range(0, 15));
      #1;
      check_all($sformatf("rand%0d", c));
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/phys_reg_file.md
# phys_reg_file

Parametrised physical register file for the renamed MIPS core: `NUM_RD` asynchronous read ports, `NUM_WR` synchronous write-back ports, and one ready (not-busy) bit per physical register. Rename sets a register busy when it allocates it as a destination; write-back writes data and clears busy. Issue/operand-fetch reads data plus readiness through the ports. Same-cycle write-to-read bypass and a flush that marks every register ready are included.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data bits per register
- `NUM_PREGS`, 64, physical registers; `AW = $clog2(NUM_PREGS)`
- `NUM_RD`, 4, read ports
- `NUM_WR`, 2, write ports

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `rd_addr`  in  NUM_RD*AW  read addresses, port i at bits [i*AW +: AW]
- `rd_data`  out  NUM_RD*DATA_WIDTH  read data per port
- `rd_ready`  out  NUM_RD  operand ready per port
- `alloc_en`  in  1  rename allocates `alloc_addr` as a destination
- `alloc_addr`  in  AW  allocated physical register
- `wr_en`  in  NUM_WR  write-back valid per port
- `wr_addr`  in  NUM_WR*AW  write addresses
- `wr_data`  in  NUM_WR*DATA_WIDTH  write data
- `flush`  in  1  squash: mark all registers ready
- `commit_valid`  out  NUM_WR  registered: port i wrote a non-zero register last cycle
- `wr_conflict`  out  1  sticky: two write ports hit the same non-zero address in one cycle

## Operation
- Preg 0 is hardwired. It reads 0 and is always ready. Writes and allocs to it are ignored.
- Read port i is combinational.
  - If any `wr_en[j]` has `wr_addr[j] == rd_addr[i] != 0`, then `rd_data` is that `wr_data[j]` (highest j wins) and `rd_ready = 1`.
  - Otherwise `rd_data = regs[rd_addr[i]]` and `rd_ready = ready[rd_addr[i]]`.
- Write: on the edge, for each `wr_en[j]` with non-zero address, the register is set to `wr_data[j]` and its ready bit to 1. For duplicate addresses, the highest j wins and `wr_conflict` is set.
- Alloc: on the edge, `ready[alloc_addr] <= 0`, unless `alloc_addr == 0`. Data is untouched.
- Priority on a ready bit in one cycle, highest first:
  1. `flush`: all bits set to 1 and the alloc is dropped. Writes still update data.
  2. alloc: the bit is cleared, even if a write hits the same address; the data write still lands.
  3. write: the bit is set.
- `commit_valid[j] <= wr_en[j] && wr_addr[j] != 0`.
- `wr_conflict` is cleared only by `rst`.

## Timing
- Reset (async assert, values hold while `rst` = 1):
  - all regs 0
  - all ready bits 1
  - `commit_valid` 0
  - `wr_conflict` 0
  - `rd_data`/`rd_ready` follow these values combinationally (0 and 1 for any address)
- Read latency is 0 cycles. A written value is visible through bypass in the same cycle and from storage the next cycle.
- Alloc takes effect one cycle later: a read of `alloc_addr` in the alloc cycle still returns the old ready bit.
- `commit_valid` lags its write by exactly 1 cycle.
- `rst` asserted mid-operation discards all pending writes and allocs in that cycle.
- No handshake: every port is accepted in every cycle. The upstream blocks guarantee legal addresses (`< NUM_PREGS`).

## Test plan
- Reset, then read ports 0..3 at addresses 0, 5, 63, 17 -> all `rd_data` 0, all `rd_ready` 1; `commit_valid` 0, `wr_conflict` 0.
- Alloc 5 in cycle 1, write 5 = 0xDEADBEEF on port 1 in cycle 3, read 5 in cycles 2, 3 and 4 -> cycle 2 ready 0; cycle 3 ready 1 with data 0xDEADBEEF (bypass); cycle 4 same from storage; `commit_valid` = 2'b10 in cycle 4.
- Write to address 0 with 0x1234 -> address 0 still reads 0 and ready 1; `commit_valid` stays 0.
- Ports 0 and 1 both write address 9 (0x11 and 0x22) -> next cycle reads 0x22; `wr_conflict` = 1 and stays 1 until `rst`.
- Alloc 7, 8, 9 over three cycles, then `flush` together with alloc 10 -> next cycle 7, 8, 9, 10 all ready 1.
- Alloc 12 together with a write to 12 = 0xAA -> next cycle `rd_data` 0xAA, `rd_ready` 0. Then assert `rst` mid-stream -> all data 0 and all ready 1 immediately.
